b4to1_arbiter: RTL and testbench

B4TO1_ARBITER -- requirements
Module: b4to1_arbiter

---
 rtl/b4to1_arbiter_pkg.sv | 30 +++
 rtl/b4to1_muxer.sv | 18 +
 rtl/b4to1_arbiter.sv | 126 ++++++++++++
 tb/tb_b4to1_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/b4to1_arbiter_pkg.sv
// Shared constants for the 4-to-1 round-robin bus arbiter: state encodings,
// default hold limit and the rotating-priority pick function.
package b4to1_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } arb_state_t;

    localparam int HOLD_MAX_DEFAULT = 8;

    // First asserted request in the order last+1, last+2, last+3, last.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/b4to1_muxer.sv
// Combinational 4:1 data-line selector; the registered result lives in the arbiter.
module b4to1_muxer (
    input  logic [3:0] data,
    input  logic [1:0] sel,
    output logic       out
);

    logic [3:0] hit;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sel
            assign hit[gi] = data[gi] & (sel == 2'(gi));
        end
    endgenerate

    assign out = |hit;

endmodule

// File: rtl/b4to1_arbiter.sv
// 4-requester round-robin arbiter with a one-cycle GAP between owners and a
// registered data tap. Optional per-owner hold limit: define B4TO1_ARB_TIMEOUT_EN.
module b4to1_arbiter
    import b4to1_arbiter_pkg::*;
#(
    parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] x3_x0,
    output logic [3:0] grant,
    output logic [1:0] b1_b0,
    output logic       z0,
    output logic       valid,
    output logic       busy
);

    arb_state_t state_reg, state_next;
    logic [3:0] grant_reg, grant_next;
    logic [1:0] sel_reg,   sel_next;
    logic [1:0] last_reg,  last_next;
    logic       z_reg,     z_next;
    logic       valid_reg, valid_next;
    logic [1:0] pick;
    logic       mux_out;
    logic       expire;

    b4to1_muxer u_muxer (
        .data (x3_x0),
        .sel  (sel_reg),
        .out  (mux_out)
    );

    assign pick = rr_pick(req, last_reg);

`ifdef B4TO1_ARB_TIMEOUT_EN
    localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    logic [CW-1:0] cnt_reg, cnt_next;

    // cnt_reg counts completed GRANT cycles minus one; the HOLD_MAX-th edge releases.
    assign expire = (cnt_reg == CW'(HOLD_MAX - 1));

    always_comb begin
        cnt_next = cnt_reg;
        if (state_reg == ST_GRANT)
            cnt_next = expire ? '0 : cnt_reg + 1'b1;
        else
            cnt_next = '0;
    end

    always_ff @(posedge clock) begin
        if (reset)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_next;
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        sel_next   = sel_reg;
        last_next  = last_reg;
        z_next     = z_reg;
        valid_next = valid_reg;
        case (state_reg)
            ST_IDLE, ST_GAP: begin
                valid_next = 1'b0;
                if (|req) begin
                    state_next = ST_GRANT;
                    grant_next = 4'b0001 << pick;
                    sel_next   = pick;
                    last_next  = pick;
                end else begin
                    state_next = ST_IDLE;
                    grant_next = 4'b0000;
                end
            end
            ST_GRANT: begin
                z_next = mux_out;
                // Owner release always passes through GAP, even with others waiting.
                if (req[sel_reg] && !expire) begin
                    valid_next = 1'b1;
                end else begin
                    state_next = ST_GAP;
                    grant_next = 4'b0000;
                    valid_next = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = 4'b0000;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            grant_reg <= 4'b0000;
            sel_reg   <= 2'b00;
            last_reg  <= 2'b11;
            z_reg     <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            sel_reg   <= sel_next;
            last_reg  <= last_next;
            z_reg     <= z_next;
            valid_reg <= valid_next;
        end
    end

    assign grant = grant_reg;
    assign b1_b0 = sel_reg;
    assign z0    = z_reg;
    assign valid = valid_reg;
    assign busy  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_b4to1_arbiter.sv
// Table-driven bench for b4to1_arbiter; each row is one clock of stimulus and
// the outputs expected after that edge. Build with B4TO1_ARB_TIMEOUT_EN for the hold-limit case.
module tb_b4to1_arbiter;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] x;
        logic [3:0] g;
        logic [1:0] s;
        logic       v;
        logic       zc;
        logic       z;
        logic       b;
    } row_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = 4'b0000;
    logic [3:0] x3_x0 = 4'b0000;
    logic [3:0] grant;
    logic [1:0] b1_b0;
    logic       z0;
    logic       valid;
    logic       busy;

    int   checks   = 0;
    int   failures = 0;
    row_t vec[$];
    row_t exp_q[$];

    b4to1_arbiter #(.HOLD_MAX(4)) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .x3_x0 (x3_x0),
        .grant (grant),
        .b1_b0 (b1_b0),
        .z0    (z0),
        .valid (valid),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    task automatic add(input logic rst, input logic [3:0] rq, input logic [3:0] x,
                       input logic [3:0] g, input logic [1:0] s, input logic v,
                       input logic zc, input logic z, input logic b);
        row_t r;
        r.rst = rst; r.req = rq; r.x = x; r.g = g; r.s = s;
        r.v = v; r.zc = zc; r.z = z; r.b = b;
        vec.push_back(r);
    endtask

    // Reset for two cycles; every output must read its reset value.
    task automatic add_reset();
        add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 1, 0, 0);
        add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 1, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        row_t e;
        logic ok;

        // Single request from idle: 1-cycle grant latency, data valid one cycle later.
        add_reset();
        add(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 0, 1, 0, 1);
        add(0, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1, 1, 1, 1);
        add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 1, 0, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, 0, 0, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, 1, 0, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 2'd2, 0, 1, 0, 0);

        // All requesting; each owner drops after 3 grant cycles -> full rotation with GAPs.
        add_reset();
        add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0, 0, 0, 1);
        add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0, 0, 1);
        add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1, 0, 0, 1);
        add(0, 4'b1110, 4'b0000, 4'b0000, 2'd0, 0, 0, 0, 1);
        add(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 0, 0, 0, 1);
        add(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1, 0, 0, 1);
        add(0, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1, 0, 0, 1);
        add(0, 4'b1101, 4'b0000, 4'b0000, 2'd1, 0, 0, 0, 1);
        add(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 0, 0, 0, 1);
        add(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1, 0, 0, 1);
        add(0, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1, 0, 0, 1);
        add(0, 4'b1011, 4'b0000, 4'b0000, 2'd2, 0, 0, 0, 1);
        add(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 0, 0, 0, 1);
        add(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1, 0, 0, 1);
        add(0, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1, 0, 0, 1);
        add(0, 4'b0111, 4'b0000, 4'b0000, 2'd3, 0, 0, 0, 1);
        add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0, 0, 0, 1);

        // Owner 1 drops while 3 and 0 wait: GAP, then 3 wins over 0.
        add_reset();
        add(0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 0, 0, 0, 1);
        add(0, 4'b1011, 4'b0000, 4'b0010, 2'd1, 1, 0, 0, 1);
        add(0, 4'b1001, 4'b0000, 4'b0000, 2'd1, 0, 0, 0, 1);
        add(0, 4'b1001, 4'b0000, 4'b1000, 2'd3, 0, 0, 0, 1);

        // Reset mid-GRANT: no GAP, all cleared; requester 0 wins next.
        add_reset();
        add(0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 0, 0, 0, 1);
        add(0, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1, 1, 1, 1);
        add(1, 4'b0010, 4'b0010, 4'b0000, 2'd0, 0, 1, 0, 0);
        add(0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 0, 1, 0, 1);

        // Data tap follows the owner's line only; other lines toggle opposite.
        add_reset();
        add(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0, 1, 0, 1);
        add(0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1, 1, 1, 1);
        add(0, 4'b0001, 4'b1110, 4'b0001, 2'd0, 1, 1, 0, 1);
        add(0, 4'b0001, 4'b0001, 4'b0001, 2'd0, 1, 1, 1, 1);
        add(0, 4'b0000, 4'b1110, 4'b0000, 2'd0, 0, 0, 0, 1);

        // Constant single request: hold limit behaviour depends on the build.
        add_reset();
        add(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0, 0, 0, 1);
`ifdef B4TO1_ARB_TIMEOUT_EN
        add(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0, 0, 1);
        add(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0, 0, 1);
        add(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0, 0, 1);
        add(0, 4'b0001, 4'b0000, 4'b0000, 2'd0, 0, 0, 0, 1);
        add(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 0, 0, 0, 1);
        add(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0, 0, 1);
`else
        for (int i = 0; i < 12; i++)
            add(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0, 0, 1);
`endif

        @(negedge clock);
        for (int i = 0; i < vec.size(); i++) begin
            reset = vec[i].rst;
            req   = vec[i].req;
            x3_x0 = vec[i].x;
            exp_q.push_back(vec[i]);
            @(negedge clock);
            e  = exp_q.pop_front();
            ok = 1'b1;
            if (grant !== e.g)
                ok = 1'b0;
            if (b1_b0 !== e.s)
                ok = 1'b0;
            if (valid !== e.v)
                ok = 1'b0;
            if (busy !== e.b)
                ok = 1'b0;
            if (e.zc && (z0 !== e.z))
                ok = 1'b0;
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL row%0d: got grant=%b b1_b0=%0d valid=%b z0=%b busy=%b, want grant=%b b1_b0=%0d valid=%b z0=%s busy=%b",
                         i, grant, b1_b0, valid, z0, busy, e.g, e.s, e.v,
                         e.zc ? (e.z ? "1" : "0") : "-", e.b);
            end else begin
                $display("row%0d rst=%b req=%b x=%b -> grant=%b b1_b0=%0d valid=%b z0=%b busy=%b ok",
                         i, e.rst, e.req, e.x, grant, b1_b0, valid, z0, busy);
            end
        end

        if ((checks != vec.size()) || (failures != 0))
            $display("FAIL summary: checks=%0d rows=%0d failures=%0d", checks, vec.size(), failures);
        else
            $display("PASS summary: checks=%0d rows=%0d", checks, vec.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
